// File: rtl/count_mod_bcd_pkg.sv
// Shared BCD digit type, digit limits and BCD<->binary helpers for count_mod_bcd.
// Up to four decades are supported, so every helper works on a 16-bit BCD word.
package count_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam bcd_t BCD_MIN    = 4'd0;
    localparam int   MAX_DIGITS = 4;

    function automatic logic [15:0] bcd_to_bin(input logic [15:0] bcd);
        logic [15:0] acc;
        acc = 16'd0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            acc = 16'(acc * 16'd10) + 16'(bcd[4*i +: 4]);
        end
        return acc;
    endfunction

    function automatic logic [15:0] bin_to_bcd(input int bin);
        logic [15:0] bcd;
        int          rem;
        bcd = 16'd0;
        rem = bin;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(rem % 32'sd10);
            rem           = rem / 32'sd10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/count_mod_bcd_if.sv
// Control/status bundle of the modulo BCD counter; port up exists only when
// COUNT_DOWN_EN is defined.
interface count_mod_bcd_if #(
    parameter int DIGITS = 2
);
    logic                  en;
`ifdef COUNT_DOWN_EN
    logic                  up;
`endif
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  co;
    logic                  load_err;

    modport master (
        output en,
`ifdef COUNT_DOWN_EN
        output up,
`endif
        output clr,
        output load,
        output load_val,
        input  count,
        input  co,
        input  load_err
    );

    modport slave (
        input  en,
`ifdef COUNT_DOWN_EN
        input  up,
`endif
        input  clr,
        input  load,
        input  load_val,
        output count,
        output co,
        output load_err
    );
endinterface

// File: rtl/count_mod_bcd_digit.sv
// One BCD decade: load has priority over inc/dec; cout/bout are the combinational
// ripple carry and borrow into the next decade.
module bcd_digit
    import count_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic load,
    input  bcd_t d,
    output bcd_t q,
    output logic cout,
    output logic bout
);

    bcd_t q_q;
    bcd_t q_d;

    // Next digit value: load, then 9->0 / 0->9 wrapping step, else hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : bcd_t'(q_q + 4'd1);
        end else if (dec) begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : bcd_t'(q_q - 4'd1);
        end else begin
            q_d = q_q;
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BCD_MIN;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign cout = inc & (q_q == BCD_MAX);
    assign bout = dec & (q_q == BCD_MIN);

endmodule

// File: rtl/count_mod_bcd.sv
// Modulo-MODULUS BCD counter built from bcd_digit decades; the top owns clear,
// checked load and terminal-count wrap. Define COUNT_DOWN_EN for the up/down variant.
module count_mod_bcd
    import count_pkg::*;
#(
    parameter int MODULUS = 60,
    parameter int DIGITS  = 2
)
(
    input  logic            clk,
    input  logic            rst,
    count_mod_bcd_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("count_mod_bcd: DIGITS must be in 1..4");
    end else if (MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_modulus
        $error("count_mod_bcd: MODULUS must be in 2..10**DIGITS");
    end

    localparam logic [15:0]  LAST_BCD16 = bin_to_bcd(MODULUS - 1);
    localparam logic [W-1:0] LAST_BCD   = LAST_BCD16[W-1:0];
    localparam logic [15:0]  LAST_BIN   = 16'(MODULUS - 1);
    localparam logic [15:0]  MOD_BIN    = 16'(MODULUS);

    logic              up_s;
    logic              at_max_s;
    logic              at_zero_s;
    logic              digits_ok_s;
    logic              load_ok_s;
    logic              step_up_s;
    logic              step_dn_s;
    logic              dig_load_s;
    logic [W-1:0]      dig_data_s;
    logic              co_s;
    logic              load_err_d;
    logic              load_err_q;
    logic [W-1:0]      count_s;
    logic [DIGITS-1:0] inc_s;
    logic [DIGITS-1:0] dec_s;
    logic [DIGITS-1:0] cout_s;
    logic [DIGITS-1:0] bout_s;
    logic              unused_chain_s;

`ifdef COUNT_DOWN_EN
    assign up_s = bus.up;
`else
    assign up_s = 1'b1;
`endif

    assign at_max_s  = (bcd_to_bin(16'(count_s)) == LAST_BIN);
    assign at_zero_s = (count_s == {W{1'b0}});

    // A load is legal only when every nibble is a decimal digit and the value fits.
    always_comb begin
        digits_ok_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] > BCD_MAX) begin
                digits_ok_s = 1'b0;
            end else begin
                digits_ok_s = digits_ok_s;
            end
        end
    end

    assign load_ok_s = digits_ok_s & (bcd_to_bin(16'(bus.load_val)) < MOD_BIN);

    // Edge priority clr > load > en > hold; terminal counts wrap via a parallel digit load.
    always_comb begin
        dig_load_s = 1'b0;
        dig_data_s = {W{1'b0}};
        step_up_s  = 1'b0;
        step_dn_s  = 1'b0;
        load_err_d = 1'b0;
        co_s       = 1'b0;
        if (bus.clr) begin
            dig_load_s = 1'b1;
        end else if (bus.load) begin
            if (load_ok_s) begin
                dig_load_s = 1'b1;
                dig_data_s = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (up_s) begin
                co_s = at_max_s & ~rst;
                if (at_max_s) begin
                    dig_load_s = 1'b1;
                end else begin
                    step_up_s = 1'b1;
                end
            end else begin
                co_s = at_zero_s & ~rst;
                if (at_zero_s) begin
                    dig_load_s = 1'b1;
                    dig_data_s = LAST_BCD;
                end else begin
                    step_dn_s = 1'b1;
                end
            end
        end else begin
            dig_load_s = 1'b0;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign inc_s[i] = step_up_s;
            assign dec_s[i] = step_dn_s;
        end else begin : g_upper
            assign inc_s[i] = cout_s[i-1];
            assign dec_s[i] = bout_s[i-1];
        end

        bcd_digit u_digit (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc_s[i]),
            .dec  (dec_s[i]),
            .load (dig_load_s),
            .d    (dig_data_s[4*i +: 4]),
            .q    (count_s[4*i +: 4]),
            .cout (cout_s[i]),
            .bout (bout_s[i])
        );
    end

    // The top decade never ripples further: wrap is handled by the parallel load.
    assign unused_chain_s = cout_s[DIGITS-1] | bout_s[DIGITS-1];

    // Rejected-load flag, a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_s;
    assign bus.co       = co_s;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_count_mod_bcd.sv
// Directed bench for count_mod_bcd: vector table on a MOD-60 counter plus hand
// sequences for wrap, async reset, down count (COUNT_DOWN_EN) and a 60x24 cascade.
module tb_count_mod_bcd;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    count_mod_bcd_if #(.DIGITS(2)) bus0 ();
    count_mod_bcd_if #(.DIGITS(2)) bus_a ();
    count_mod_bcd_if #(.DIGITS(2)) bus_b ();

    count_mod_bcd #(.MODULUS(60), .DIGITS(2)) dut0   (.clk(clk), .rst(rst), .bus(bus0));
    count_mod_bcd #(.MODULUS(60), .DIGITS(2)) dut_a  (.clk(clk), .rst(rst), .bus(bus_a));
    count_mod_bcd #(.MODULUS(24), .DIGITS(2)) dut_b  (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.en = bus_a.co;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       load;
        logic       en;
        logic [7:0] lv;
        logic       co;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        bus0.clr      = v.clr;
        bus0.load     = v.load;
        bus0.en       = v.en;
        bus0.load_val = v.lv;
        #1 chk($sformatf("vec%0d_co", idx), 32'(bus0.co), 32'(v.co));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_count", idx), 32'(bus0.count), 32'(v.cnt));
        chk($sformatf("vec%0d_load_err", idx), 32'(bus0.load_err), 32'(v.err));
    endtask

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h45, 1'b0, 8'h45, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h46, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h60, 1'b0, 8'h46, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h46, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h3A, 1'b0, 8'h46, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h09, 1'b0, 8'h09, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h10, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h59, 1'b0, 8'h59, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h59, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h58, 1'b0, 8'h58, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 8'h58, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h37, 1'b0, 8'h37, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h7A, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 1'b0};

        // Reset state, with en high so co must still be held low.
        rst            = 1'b1;
        bus0.en        = 1'b1;
        bus0.clr       = 1'b0;
        bus0.load      = 1'b0;
        bus0.load_val  = 8'h00;
        bus_a.en       = 1'b0;
        bus_a.clr      = 1'b0;
        bus_a.load     = 1'b0;
        bus_a.load_val = 8'h00;
        bus_b.clr      = 1'b0;
        bus_b.load     = 1'b0;
        bus_b.load_val = 8'h00;
`ifdef COUNT_DOWN_EN
        bus0.up  = 1'b1;
        bus_a.up = 1'b1;
        bus_b.up = 1'b1;
`endif
        #1;
        chk("rst_count", 32'(bus0.count), 32'h00);
        chk("rst_load_err", 32'(bus0.load_err), 32'h0);
        chk("rst_co", 32'(bus0.co), 32'h0);
        @(posedge clk);
        #1 chk("rst_hold_count", 32'(bus0.count), 32'h00);
        @(negedge clk);
        bus0.en = 1'b0;
        rst     = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], i);
        end

        // Full up-count wrap from a fresh reset, released with en already high.
        @(negedge clk);
        rst       = 1'b1;
        bus0.clr  = 1'b0;
        bus0.load = 1'b0;
        bus0.en   = 1'b1;
        #2 rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            chk($sformatf("wrap%0d_count", i), 32'(bus0.count), 32'(to_bcd(i)));
            chk($sformatf("wrap%0d_co", i), 32'(bus0.co), 32'(i == 59));
            @(posedge clk);
            @(negedge clk);
        end
        #1 chk("wrap_end_count", 32'(bus0.count), 32'h00);

        // Asynchronous reset between edges at count 0x37, with a load_err pulse live.
        @(negedge clk);
        bus0.en       = 1'b0;
        bus0.load     = 1'b1;
        bus0.load_val = 8'h37;
        @(negedge clk);
        bus0.load_val = 8'h6F;
        @(posedge clk);
        #1;
        chk("async_pre_count", 32'(bus0.count), 32'h37);
        chk("async_pre_err", 32'(bus0.load_err), 32'h1);
        bus0.load = 1'b0;
        bus0.en   = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_count", 32'(bus0.count), 32'h00);
        chk("async_err", 32'(bus0.load_err), 32'h0);
        chk("async_co", 32'(bus0.co), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("resume_count", 32'(bus0.count), 32'h01);

`ifdef COUNT_DOWN_EN
        // Down count: 00 borrows to 59 with co, 10 borrows across the decade to 09.
        @(negedge clk);
        bus0.en       = 1'b0;
        bus0.load     = 1'b1;
        bus0.load_val = 8'h00;
        @(negedge clk);
        bus0.load = 1'b0;
        bus0.en   = 1'b1;
        bus0.up   = 1'b0;
        #1 chk("down_zero_co", 32'(bus0.co), 32'h1);
        @(posedge clk);
        #1 chk("down_wrap_count", 32'(bus0.count), 32'h59);
        @(negedge clk);
        bus0.en       = 1'b0;
        bus0.load     = 1'b1;
        bus0.load_val = 8'h10;
        @(negedge clk);
        bus0.load = 1'b0;
        bus0.en   = 1'b1;
        #1 chk("down_borrow_co", 32'(bus0.co), 32'h0);
        @(posedge clk);
        #1 chk("down_borrow_count", 32'(bus0.count), 32'h09);
        @(negedge clk);
        bus0.up = 1'b1;
        bus0.en = 1'b0;
`endif

        // Cascade MOD-60 into MOD-24 for a full 1440-step period.
        @(negedge clk);
        bus0.en  = 1'b0;
        rst      = 1'b1;
        bus_a.en = 1'b1;
        #2 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 1440; i++) begin
            #1;
            if (i == 60) begin
                chk("cascade60_a", 32'(bus_a.count), 32'h00);
                chk("cascade60_b", 32'(bus_b.count), 32'h01);
            end
            if (bus_b.co === 1'b1) begin
                pulses++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("cascade_a_count", 32'(bus_a.count), 32'h00);
        chk("cascade_b_count", 32'(bus_b.count), 32'h00);
        chk("cascade_b_co_pulses", 32'(pulses), 32'd1);
        bus_a.en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
